// File: rtl/instruction_fetch_pkg.sv
// ============================================================================
// Module      : instruction_fetch_pkg
// Description : Shared types and constants for the IF stage of the MIPS pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instruction_fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  typedef enum logic [2:0] {
    PC_SEL_HOLD   = 3'd0,
    PC_SEL_JR     = 3'd1,
    PC_SEL_JUMP   = 3'd2,
    PC_SEL_BRANCH = 3'd3,
    PC_SEL_SEQ    = 3'd4
  } pc_sel_e;

  // Redirect priority: a stall always wins, then register jumps, direct jumps, branches.
  function automatic pc_sel_e select_next_pc(
    input logic stall,
    input logic jr_jalr,
    input logic jump,
    input logic branch_taken
  );
    if (stall)             return PC_SEL_HOLD;
    else if (jr_jalr)      return PC_SEL_JR;
    else if (jump)         return PC_SEL_JUMP;
    else if (branch_taken) return PC_SEL_BRANCH;
    else                   return PC_SEL_SEQ;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_memory.sv
// ============================================================================
// Module      : instruction_memory
// Description : Instruction store with synchronous write and combinational read;
//               out-of-range reads return NOP.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_memory
  import instruction_fetch_pkg::*;
#(
  parameter int IMEM_ADDR_SIZE = 8,
  parameter int INST_SIZE      = 32
) (
  input  logic                      i_clock,
  input  logic                      i_wr_en,
  input  logic [IMEM_ADDR_SIZE-1:0] i_wr_addr,
  input  logic [INST_SIZE-1:0]      i_wr_data,
  input  logic [IMEM_ADDR_SIZE-1:0] i_rd_addr,
  input  logic                      i_rd_in_range,
  output logic [INST_SIZE-1:0]      o_rd_data
);

  localparam int IMEM_DEPTH = 2 ** IMEM_ADDR_SIZE;

  logic [INST_SIZE-1:0] mem_array [IMEM_DEPTH];

  always_ff @(posedge i_clock) begin
    if (i_wr_en) begin
      mem_array[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = i_rd_in_range ? mem_array[i_rd_addr] : INST_SIZE'(NOP_INST);

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module      : instruction_fetch
// Description : IF stage: PC register, next-PC selection, LOAD/RUN/HALTED control
//               and the IF/ID register. IFETCH_FETCH_COUNT_EN adds o_fetch_count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int PC_SIZE        = 32,
  parameter int INST_SIZE      = 32,
  parameter int IMEM_ADDR_SIZE = 8,
  parameter int IMEM_DEPTH     = 2 ** IMEM_ADDR_SIZE
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_pipeline_enable,
  input  logic                      i_stall,
  input  logic                      i_flush,
  input  logic                      i_jump,
  input  logic [PC_SIZE-1:0]        i_jump_addr,
  input  logic                      i_jr_jalr,
  input  logic [PC_SIZE-1:0]        i_jr_addr,
  input  logic                      i_branch_taken,
  input  logic [PC_SIZE-1:0]        i_branch_addr,
  input  logic                      i_halt,
  input  logic                      i_imem_wr_en,
  input  logic [IMEM_ADDR_SIZE-1:0] i_imem_wr_addr,
  input  logic [INST_SIZE-1:0]      i_imem_wr_data,
`ifdef IFETCH_FETCH_COUNT_EN
  output logic [31:0]               o_fetch_count,
`endif
  output logic [INST_SIZE-1:0]      o_inst,
  output logic [PC_SIZE-1:0]        o_pc,
  output logic [PC_SIZE-1:0]        o_pc_current,
  output logic                      o_halted
);

  fetch_state_e         state_q, state_d;
  logic [PC_SIZE-1:0]   pc_q, pc_d;
  logic [INST_SIZE-1:0] inst_q, inst_d;
  logic [PC_SIZE-1:0]   if_pc_q, if_pc_d;
  logic                 halted_q, halted_d;

  logic [INST_SIZE-1:0] fetch_inst;
  logic [PC_SIZE-1:0]   pc_plus1;
  logic                 pc_in_range;
  logic                 run_active;
  logic                 load_fire;
  pc_sel_e              pc_sel;

  assign pc_plus1    = pc_q + PC_SIZE'(1);
  assign pc_in_range = (pc_q < PC_SIZE'(IMEM_DEPTH));
  assign run_active  = (state_q == ST_RUN) && i_pipeline_enable;
  assign load_fire   = run_active && !i_halt && !i_stall && !i_flush;
  assign pc_sel      = select_next_pc(i_stall, i_jr_jalr, i_jump, i_branch_taken);

  instruction_memory #(
    .IMEM_ADDR_SIZE (IMEM_ADDR_SIZE),
    .INST_SIZE      (INST_SIZE)
  ) u_imem (
    .i_clock       (i_clock),
    .i_wr_en       (i_imem_wr_en && (state_q == ST_LOAD)),
    .i_wr_addr     (i_imem_wr_addr),
    .i_wr_data     (i_imem_wr_data),
    .i_rd_addr     (pc_q[IMEM_ADDR_SIZE-1:0]),
    .i_rd_in_range (pc_in_range),
    .o_rd_data     (fetch_inst)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if_pc_d = if_pc_q;
    case (state_q)
      ST_LOAD: begin
        pc_d   = '0;
        inst_d = INST_SIZE'(NOP_INST);
        if (i_pipeline_enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (i_pipeline_enable) begin
          if (i_halt) begin
            // The halt itself must not reach decode, and the PC parks on it.
            state_d = ST_HALTED;
            inst_d  = INST_SIZE'(NOP_INST);
          end else begin
            case (pc_sel)
              PC_SEL_HOLD:   pc_d = pc_q;
              PC_SEL_JR:     pc_d = i_jr_addr;
              PC_SEL_JUMP:   pc_d = i_jump_addr;
              PC_SEL_BRANCH: pc_d = i_branch_addr;
              default:       pc_d = pc_plus1;
            endcase
            // Flush is dropped during a stall; ID repeats the redirect next cycle.
            if (!i_stall) begin
              inst_d  = i_flush ? INST_SIZE'(NOP_INST) : fetch_inst;
              if_pc_d = pc_plus1;
            end
          end
        end
      end
      ST_HALTED: begin
        inst_d = INST_SIZE'(NOP_INST);
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= ST_LOAD;
      pc_q     <= '0;
      inst_q   <= INST_SIZE'(NOP_INST);
      if_pc_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      if_pc_q  <= if_pc_d;
      halted_q <= halted_d;
    end
  end

`ifdef IFETCH_FETCH_COUNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (load_fire && (fetch_count_q != 32'hFFFF_FFFF)) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) fetch_count_q <= '0;
    else         fetch_count_q <= fetch_count_d;
  end

  assign o_fetch_count = fetch_count_q;
`else
  logic unused_load_fire;
  assign unused_load_fire = load_fire;
`endif

  assign o_inst       = inst_q;
  assign o_pc         = if_pc_q;
  assign o_pc_current = pc_q;
  assign o_halted     = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Directed self-checking bench for instruction_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, stall, flush, jump, jr, br, halt, wr_en;
  logic [31:0] jump_addr, jr_addr, br_addr, wr_data;
  logic [7:0]  wr_addr;
  logic [31:0] inst, pc_ifid, pc_cur;
  logic        halted;
`ifdef IFETCH_FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] W0 = 32'h2001_0005;
  localparam logic [31:0] W1 = 32'h2002_0003;
  localparam logic [31:0] W2 = 32'h0022_1820;
  localparam logic [31:0] W3 = 32'hFC00_0000;
  localparam logic [31:0] W5 = 32'h2005_0005;
  localparam logic [31:0] W6 = 32'h2006_0006;
  localparam logic [31:0] WTOP = 32'hABCD_0001;

  instruction_fetch dut (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_pipeline_enable (en),
    .i_stall           (stall),
    .i_flush           (flush),
    .i_jump            (jump),
    .i_jump_addr       (jump_addr),
    .i_jr_jalr         (jr),
    .i_jr_addr         (jr_addr),
    .i_branch_taken    (br),
    .i_branch_addr     (br_addr),
    .i_halt            (halt),
    .i_imem_wr_en      (wr_en),
    .i_imem_wr_addr    (wr_addr),
    .i_imem_wr_data    (wr_data),
`ifdef IFETCH_FETCH_COUNT_EN
    .o_fetch_count     (fetch_count),
`endif
    .o_inst            (inst),
    .o_pc              (pc_ifid),
    .o_pc_current      (pc_cur),
    .o_halted          (halted)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_if(input string tag, input logic [31:0] e_inst,
                           input logic [31:0] e_pc, input logic [31:0] e_cur);
    check_eq({tag, ".inst"}, inst, e_inst);
    check_eq({tag, ".pc"}, pc_ifid, e_pc);
    check_eq({tag, ".pc_cur"}, pc_cur, e_cur);
  endtask

  task automatic write_word(input logic [7:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; stall = 1'b0; flush = 1'b0; jump = 1'b0; jr = 1'b0;
    br = 1'b0; halt = 1'b0; wr_en = 1'b0; jump_addr = '0; jr_addr = '0;
    br_addr = '0; wr_data = '0; wr_addr = '0;
    step(); step();
    rst = 1'b0;
    expect_if("reset", 32'h0, 32'h0, 32'h0);
    check_eq("reset.halted", {31'd0, halted}, 32'd0);

    write_word(8'd0, W0);
    write_word(8'd1, W1);
    write_word(8'd2, W2);
    write_word(8'd3, W3);
    write_word(8'd4, 32'h2004_0004);
    write_word(8'd5, W5);
    write_word(8'd6, W6);
    write_word(8'd7, 32'h2007_0007);
    expect_if("load", 32'h0, 32'h0, 32'h0);

    // Program run and stall
    en = 1'b1;
    step(); expect_if("enter_run", 32'h0, 32'h0, 32'h0);
    step(); expect_if("fetch0", W0, 32'd1, 32'd1);
    step(); expect_if("fetch1", W1, 32'd2, 32'd2);
    stall = 1'b1;
    step(); expect_if("stall1", W1, 32'd2, 32'd2);
    step(); expect_if("stall2", W1, 32'd2, 32'd2);
    stall = 1'b0;
    step(); expect_if("fetch2", W2, 32'd3, 32'd3);
    step(); expect_if("fetch3", W3, 32'd4, 32'd4);

    // Halt at PC 4, then an ignored write
    halt = 1'b1;
    step(); halt = 1'b0;
    expect_if("halt", 32'h0, 32'd4, 32'd4);
    check_eq("halt.halted", {31'd0, halted}, 32'd1);
    write_word(8'd0, 32'hDEAD_BEEF);
    expect_if("halted_wr", 32'h0, 32'd4, 32'd4);
    check_eq("halted_wr.halted", {31'd0, halted}, 32'd1);

    rst = 1'b1; en = 1'b0;
    step(); rst = 1'b0;
    check_eq("unhalt.halted", {31'd0, halted}, 32'd0);
    en = 1'b1;
    step();
    step(); expect_if("refetch0", W0, 32'd1, 32'd1);

    // Redirect priority with flush
    jump = 1'b1; jump_addr = 32'h10; br = 1'b1; br_addr = 32'h20; flush = 1'b1;
    step(); expect_if("jump_vs_br", 32'h0, 32'd2, 32'h10);
    br = 1'b0; jr = 1'b1; jr_addr = 32'd5;
    step(); expect_if("jr_vs_jump", 32'h0, 32'h11, 32'd5);
    jr = 1'b0; jump = 1'b0; flush = 1'b0;
    step(); expect_if("fetch5", W5, 32'd6, 32'd6);
    step(); expect_if("fetch6", W6, 32'd7, 32'd7);

    // Reset mid-run at PC 7
    rst = 1'b1;
    step(); rst = 1'b0; en = 1'b0;
    expect_if("run_reset", 32'h0, 32'h0, 32'h0);
    check_eq("run_reset.halted", {31'd0, halted}, 32'd0);
    write_word(8'd255, WTOP);
    en = 1'b1;
    step();
    step(); expect_if("refetch0b", W0, 32'd1, 32'd1);

    // Top of memory and beyond
    jump = 1'b1; jump_addr = 32'hFF; flush = 1'b1;
    step(); jump = 1'b0; flush = 1'b0;
    expect_if("jump_top", 32'h0, 32'd2, 32'hFF);
    step(); expect_if("fetch_top", WTOP, 32'h100, 32'h100);
`ifdef IFETCH_FETCH_COUNT_EN
    check_eq("fetch_count", fetch_count, 32'd2);
`endif
    step(); expect_if("fetch_oob", 32'h0, 32'h101, 32'h101);
    br = 1'b1; br_addr = 32'd2;
    step(); br = 1'b0;
    expect_if("branch", 32'h0, 32'h102, 32'd2);
    step(); expect_if("after_branch", W2, 32'd3, 32'd3);
    en = 1'b0;
    step(); expect_if("freeze", W2, 32'd3, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
